// File: rtl/systolic_ctrl_pkg.sv
// Shared definitions for the systolic array sequencer.
//   state_t  : controller FSM encoding (IDLE, CLEAR, FEED, DRAIN, DONE)
//   row_w()  : width of a row index for M rows (at least 1 bit)
//   cnt_w()  : width of a counter that must reach M without wrapping
//   lane_lo(): low bit of lane 'lane' in a flat vector of 'width'-bit lanes
package systolic_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    FEED,
    DRAIN,
    DONE
  } state_t;

  function automatic int row_w(input int m);
    return (m <= 1) ? 1 : $clog2(m);
  endfunction

  function automatic int cnt_w(input int m);
    return $clog2(m + 1);
  endfunction

  function automatic int lane_lo(input int lane, input int width);
    return lane * width;
  endfunction

endpackage

// File: rtl/ctrl_delay.sv
// Fixed-length register delay line.
//   clk, rst : clock and synchronous active-high clear of every stage
//   d        : WIDTH-bit input
//   q        : d delayed by DEPTH cycles (DEPTH = 0 is a wire)
module ctrl_delay #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  if (DEPTH == 0) begin : g_pass
    logic unused_clk_rst;
    assign unused_clk_rst = clk ^ rst;
    assign q = d;
  end else begin : g_pipe
    logic [WIDTH-1:0] stage [DEPTH];

    // NOTE: non-blocking assignments make every stage take its neighbour's
    // pre-edge value, so the loop order below cannot collapse the chain.
    always_ff @(posedge clk) begin
      if (rst) begin
        // NOTE: the stages are cleared on reset on purpose: they carry row
        // tags, and a stale tag would emit a phantom result after an abort.
        for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
      end else begin
        stage[0] <= d;
        for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
      end
    end

    assign q = stage[DEPTH-1];
  end

endmodule

// File: rtl/systolic_seq_ctrl.sv
// Job sequencer for the weight-stationary systolic array.
//   start/w_in/busy/done   : job control; weights captured on accepted start
//   x_valid/x_data/x_ready : M input rows, one per accepted beat
//   arr_rst/arr_x/arr_w    : array drive (reset, skewed rows, held weights)
//   arr_y                  : raw, lane-skewed array output
//   y_valid/y_data/y_row   : deskewed result per row, in acceptance order
module systolic_seq_ctrl
  import systolic_ctrl_pkg::*;
#(
  parameter int M          = 5,
  parameter int N          = 3,
  parameter int K          = 4,
  parameter int DATA_WIDTH = 8,
  parameter int ARRAY_LAT  = N
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [DATA_WIDTH*N*K-1:0] w_in,
  output logic                      busy,
  output logic                      done,
  input  logic                      x_valid,
  input  logic [DATA_WIDTH*N-1:0]   x_data,
  output logic                      x_ready,
  output logic                      arr_rst,
  output logic [DATA_WIDTH*N-1:0]   arr_x,
  output logic [DATA_WIDTH*N*K-1:0] arr_w,
  input  logic [DATA_WIDTH*K-1:0]   arr_y,
  output logic                      y_valid,
  output logic [DATA_WIDTH*K-1:0]   y_data,
  output logic [row_w(M)-1:0]       y_row
);

  localparam int ROW_W     = row_w(M);
  localparam int CNT_W     = cnt_w(M);
  localparam int TAG_W     = ROW_W + 1;
  // Tag is registered alongside lane 0, then must line up with the last
  // deskew stage, one cycle ahead of the output register.
  localparam int TAG_DEPTH = ARRAY_LAT + K - 1;

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   in_cnt, out_cnt;
  logic               accept, last_in, last_out;

  logic [DATA_WIDTH*N-1:0] x_stage0;
  logic [TAG_W-1:0]        tag_stage0, tag_out;
  logic [DATA_WIDTH*K-1:0] y_aligned;

  assign accept   = x_valid && x_ready;
  assign last_in  = accept && (in_cnt == CNT_W'(M - 1));
  assign last_out = y_valid && (out_cnt == CNT_W'(M - 1));

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    // NOTE: default first so every path assigns state_nxt and no latch forms.
    state_nxt = state;
    case (state)
      IDLE:    if (start)    state_nxt = CLEAR;
      CLEAR:                 state_nxt = FEED;
      FEED:    if (last_in)  state_nxt = DRAIN;
      DRAIN:   if (last_out) state_nxt = DONE;
      DONE:                  state_nxt = IDLE;
      default:               state_nxt = IDLE;
    endcase
  end

  // Output decode
  always_comb begin
    busy    = 1'b1;
    done    = 1'b0;
    x_ready = 1'b0;
    arr_rst = 1'b0;
    case (state)
      IDLE:    begin busy = 1'b0; arr_rst = 1'b1; end
      CLEAR:   arr_rst = 1'b1;
      FEED:    x_ready = 1'b1;
      DRAIN:   ;
      DONE:    done = 1'b1;
      default: begin busy = 1'b0; arr_rst = 1'b1; end
    endcase
  end

  // Weight hold and job counters; out_cnt counts result beats, which can
  // begin while rows are still being fed.
  always_ff @(posedge clk) begin
    if (rst) begin
      arr_w   <= '0;
      in_cnt  <= '0;
      out_cnt <= '0;
    end else begin
      if (state == IDLE && start) begin
        arr_w   <= w_in;
        in_cnt  <= '0;
        out_cnt <= '0;
      end
      if (accept)  in_cnt  <= in_cnt + CNT_W'(1);
      if (y_valid) out_cnt <= out_cnt + CNT_W'(1);
    end
  end

  // Entry register: a non-accepted slot enters the array as a zero row
  // with a cleared tag, so bubbles never produce results.
  always_ff @(posedge clk) begin
    if (rst) begin
      x_stage0   <= '0;
      tag_stage0 <= '0;
    end else begin
      x_stage0   <= accept ? x_data : '0;
      tag_stage0 <= accept ? {1'b1, in_cnt[ROW_W-1:0]} : '0;
    end
  end

  // Input skew: lane n lags lane 0 by n cycles.
  for (genvar n = 0; n < N; n++) begin : g_skew
    ctrl_delay #(.WIDTH(DATA_WIDTH), .DEPTH(n)) u_skew (
      .clk (clk),
      .rst (rst),
      .d   (x_stage0[lane_lo(n, DATA_WIDTH) +: DATA_WIDTH]),
      .q   (arr_x[lane_lo(n, DATA_WIDTH) +: DATA_WIDTH])
    );
  end

  ctrl_delay #(.WIDTH(TAG_W), .DEPTH(TAG_DEPTH)) u_tag (
    .clk (clk),
    .rst (rst),
    .d   (tag_stage0),
    .q   (tag_out)
  );

  // Output deskew: lane k arrives k cycles after lane 0, so it waits
  // K-1-k cycles for the slowest lane.
  for (genvar k = 0; k < K; k++) begin : g_deskew
    ctrl_delay #(.WIDTH(DATA_WIDTH), .DEPTH(K - 1 - k)) u_deskew (
      .clk (clk),
      .rst (rst),
      .d   (arr_y[lane_lo(k, DATA_WIDTH) +: DATA_WIDTH]),
      .q   (y_aligned[lane_lo(k, DATA_WIDTH) +: DATA_WIDTH])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      y_valid <= 1'b0;
      y_data  <= '0;
      y_row   <= '0;
    end else begin
      y_valid <= tag_out[ROW_W];
      y_data  <= tag_out[ROW_W] ? y_aligned : '0;
      y_row   <= tag_out[ROW_W] ? tag_out[ROW_W-1:0] : '0;
    end
  end

endmodule
